binary_down_timer: RTL and testbench

- Loadable binary down-counter/timer; the counting-down counterpart to the team's loadable binary up counter.
- Counts a loaded value down to its terminal count and emits a one-cycle terminal-count pulse.
- Supports one-shot and periodic (auto-reload) modes, plus pause/resume.
- Used as the tick/timeout generator beside the up counter in the same clock domain.

---
 rtl/binary_timer_pkg.sv | 14 +
 rtl/binary_down_counter.sv | 54 +++++
 rtl/binary_down_timer.sv | 133 +++++++++++++
 tb/tb_binary_down_timer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_timer_pkg.sv
// Shared definitions for the binary down timer: FSM state encoding and the
// default counter width.
package binary_timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_t;

endpackage : binary_timer_pkg

// File: rtl/binary_down_counter.sv
// WIDTH-bit down counter with synchronous load and decrement enable.
// The is_one/is_zero flags are registered alongside the count so the
// timer FSM can react to the terminal value without a wide compare
// sitting in front of its own next-state logic.
module binary_down_counter
    import binary_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_one,
    output logic             is_zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             is_one_reg;
    logic             is_zero_reg;

    // Next count: load wins over decrement; decrement saturates at zero
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (dec && !is_zero_reg) begin
            count_next = count_reg - ONE;
        end
    end

    // Count register plus flags derived from the value being stored
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            is_one_reg  <= 1'b0;
            is_zero_reg <= 1'b1;
        end else begin
            count_reg   <= count_next;
            is_one_reg  <= (count_next == ONE);
            is_zero_reg <= (count_next == '0);
        end
    end

    assign count   = count_reg;
    assign is_one  = is_one_reg;
    assign is_zero = is_zero_reg;

endmodule : binary_down_counter

// File: rtl/binary_down_timer.sv
// Loadable down timer: one-shot or auto-reload, with pause/resume.
// Emits a one-cycle registered tc pulse on the edge the count leaves 1.
// Input priority: rst > load > stop > start > counting.
module binary_down_timer
    import binary_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    timer_state_t     state_reg;
    timer_state_t     state_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic             tc_reg;
    logic             tc_next;
    logic             done_reg;
    logic             done_next;

    logic             cnt_load;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_dec;
    logic             cnt_is_one;
    logic             cnt_is_zero;

    binary_down_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .count      (count),
        .is_one     (cnt_is_one),
        .is_zero    (cnt_is_zero)
    );

    // FSM next state and counter control; stop masks start in every state
    always_comb begin
        state_next  = state_reg;
        reload_next = reload_reg;
        done_next   = done_reg;
        tc_next     = 1'b0;
        cnt_load    = 1'b0;
        cnt_value   = data;
        cnt_dec     = 1'b0;

        if (load) begin
            // Load abandons whatever was running and parks in IDLE
            reload_next = data;
            cnt_load    = 1'b1;
            cnt_value   = data;
            done_next   = 1'b0;
            state_next  = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Starting from zero would never terminate; ignore it
                    if (!stop && start && !cnt_is_zero) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_next = ST_PAUSED;
                    end else if (cnt_is_one) begin
                        // Terminal edge; periodic is only looked at here
                        tc_next = 1'b1;
                        if (periodic) begin
                            cnt_load  = 1'b1;
                            cnt_value = reload_reg;
                        end else begin
                            cnt_dec    = 1'b1;
                            done_next  = 1'b1;
                            state_next = ST_DONE;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!stop && start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Re-trigger from the stored reload value
                    if (!stop && start && (reload_reg != '0)) begin
                        cnt_load   = 1'b1;
                        cnt_value  = reload_reg;
                        done_next  = 1'b0;
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, reload value and the registered tc/done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            reload_reg <= '0;
            tc_reg     <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            reload_reg <= reload_next;
            tc_reg     <= tc_next;
            done_reg   <= done_next;
        end
    end

    assign tc   = tc_reg;
    assign done = done_reg;
    assign busy = (state_reg == ST_RUN);

endmodule : binary_down_timer

// File: tb/tb_binary_down_timer.sv
// Directed bench for binary_down_timer (WIDTH=4, 10 ns clock).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_binary_down_timer;

    logic       clk;
    logic       rst;
    logic [3:0] data;
    logic       load;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    binary_down_timer #(
        .WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .load     (load),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] value);
        data = value;
        load = 1'b1;
        tick();
        load = 1'b0;
        $display("load data=%0d -> count=%0d busy=%0b done=%0b", value, count, busy, done);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        $display("start -> count=%0d busy=%0b tc=%0b", count, busy, tc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        $display("reset -> count=%0d tc=%0b busy=%0b done=%0b", count, tc, busy, done);
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %0b want 0", tc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        do_start();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_at_zero_busy: got %0b want 0", busy); end
        tick();
        checks++;
        if (count !== 4'd0 || tc !== 1'b0) begin
            errors++; $display("FAIL start_at_zero_count: got count=%0d tc=%0b want 0/0", count, tc);
        end
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_count;
        periodic = 1'b0;
        do_load(4'd13);
        checks++;
        if (count !== 4'd13 || busy !== 1'b0) begin
            errors++; $display("FAIL oneshot_load: got count=%0d busy=%0b want 13/0", count, busy);
        end
        do_start();
        checks++;
        if (count !== 4'd13 || busy !== 1'b1 || tc !== 1'b0) begin
            errors++; $display("FAIL oneshot_accept: got count=%0d busy=%0b tc=%0b want 13/1/0", count, busy, tc);
        end
        for (int i = 1; i <= 13; i++) begin
            tick();
            exp_count = 4'(13 - i);
            checks++;
            if (count !== exp_count || tc !== (i == 13)) begin
                errors++;
                $display("FAIL oneshot_edge%0d: got count=%0d tc=%0b want %0d/%0b", i, count, tc, exp_count, (i == 13));
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL oneshot_end: got done=%0b busy=%0b want 1/0", done, busy);
        end
        tick();
        tick();
        checks++;
        if (count !== 4'd0 || tc !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL oneshot_hold: got count=%0d tc=%0b done=%0b want 0/0/1", count, tc, done);
        end
    endtask

    task automatic test_periodic();
        logic [3:0] exp_count;
        logic       exp_tc;
        periodic = 1'b1;
        do_load(4'd3);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL periodic_load_done: got %0b want 0", done); end
        do_start();
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_count = (i % 3 == 0) ? 4'd3 : 4'(3 - (i % 3));
            exp_tc    = (i % 3 == 0);
            checks++;
            if (count !== exp_count || tc !== exp_tc || busy !== 1'b1) begin
                errors++;
                $display("FAIL periodic_edge%0d: got count=%0d tc=%0b busy=%0b want %0d/%0b/1", i, count, tc, busy, exp_count, exp_tc);
            end
        end
        periodic = 1'b0;
        tick();
        tick();
        checks++;
        if (count !== 4'd1 || tc !== 1'b0) begin
            errors++; $display("FAIL periodic_off_pre: got count=%0d tc=%0b want 1/0", count, tc);
        end
        tick();
        checks++;
        if (count !== 4'd0 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL periodic_off_end: got count=%0d tc=%0b done=%0b busy=%0b want 0/1/1/0", count, tc, done, busy);
        end

        // reload of 1 fires tc on every edge
        periodic = 1'b1;
        do_load(4'd1);
        do_start();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (count !== 4'd1 || tc !== 1'b1) begin
                errors++; $display("FAIL periodic_one_edge%0d: got count=%0d tc=%0b want 1/1", i, count, tc);
            end
        end
        periodic = 1'b0;
        tick();
        checks++;
        if (count !== 4'd0 || tc !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL periodic_one_end: got count=%0d tc=%0b done=%0b want 0/1/1", count, tc, done);
        end
    endtask

    task automatic test_pause();
        periodic = 1'b0;
        do_load(4'd8);
        do_start();
        tick();
        tick();
        tick();
        checks++;
        if (count !== 4'd5) begin errors++; $display("FAIL pause_pre: got count=%0d want 5", count); end
        stop = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (count !== 4'd5 || busy !== 1'b0 || tc !== 1'b0) begin
                errors++; $display("FAIL pause_hold%0d: got count=%0d busy=%0b tc=%0b want 5/0/0", i, count, busy, tc);
            end
        end
        stop = 1'b0;
        do_start();
        checks++;
        if (count !== 4'd5 || busy !== 1'b1) begin
            errors++; $display("FAIL pause_resume: got count=%0d busy=%0b want 5/1", count, busy);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (count !== 4'(5 - i) || tc !== (i == 5)) begin
                errors++; $display("FAIL pause_edge%0d: got count=%0d tc=%0b want %0d/%0b", i, count, tc, 5 - i, (i == 5));
            end
        end

        // stop and start together while running: stop wins
        do_load(4'd8);
        do_start();
        tick();
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (count !== 4'd7 || busy !== 1'b0) begin
            errors++; $display("FAIL pause_stop_start: got count=%0d busy=%0b want 7/0", count, busy);
        end
    endtask

    task automatic test_retrigger();
        periodic = 1'b0;
        do_load(4'd8);
        do_start();
        for (int i = 1; i <= 8; i++) tick();
        checks++;
        if (count !== 4'd0 || done !== 1'b1) begin
            errors++; $display("FAIL retrig_first_end: got count=%0d done=%0b want 0/1", count, done);
        end
        do_start();
        checks++;
        if (count !== 4'd8 || done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL retrig_accept: got count=%0d done=%0b busy=%0b want 8/0/1", count, done, busy);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (count !== 4'(8 - i) || tc !== (i == 8)) begin
                errors++; $display("FAIL retrig_edge%0d: got count=%0d tc=%0b want %0d/%0b", i, count, tc, 8 - i, (i == 8));
            end
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL retrig_done: got %0b want 1", done); end
    endtask

    task automatic test_overrides();
        periodic = 1'b0;
        do_load(4'd10);
        do_start();
        for (int i = 1; i <= 6; i++) tick();
        checks++;
        if (count !== 4'd4) begin errors++; $display("FAIL override_pre: got count=%0d want 4", count); end
        do_load(4'd10);
        checks++;
        if (count !== 4'd10 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL override_load: got count=%0d busy=%0b tc=%0b done=%0b want 10/0/0/0", count, busy, tc, done);
        end
        tick();
        checks++;
        if (count !== 4'd10 || busy !== 1'b0) begin
            errors++; $display("FAIL override_idle: got count=%0d busy=%0b want 10/0", count, busy);
        end

        // rst together with load while running
        do_start();
        tick();
        rst  = 1'b1;
        load = 1'b1;
        data = 4'd5;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        $display("rst+load -> count=%0d tc=%0b busy=%0b done=%0b", count, tc, busy, done);
        checks++;
        if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL override_rst: got count=%0d tc=%0b busy=%0b done=%0b want 0/0/0/0", count, tc, busy, done);
        end
    endtask

    initial begin
        rst      = 1'b1;
        data     = 4'd0;
        load     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        #1;
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause();
        test_retrigger();
        test_overrides();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_binary_down_timer
